// File: rtl/btn_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// btn_pulse_gen_pkg
//   Shared definitions for the push-button front end. This package holds:
//     - the FSM state type
//     - the default timing constants, which the top level can override per
//       button instance through named parameter overrides
//     - the minimum legal values for those timing constants
// -----------------------------------------------------------------------------
package btn_pulse_gen_pkg;

    // Button FSM states. The 3-bit encoding is kept for compatibility.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS_DEB = 3'd1,
        ST_HELD      = 3'd2,
        ST_REPEAT    = 3'd3,
        ST_REL_DEB   = 3'd4
    } btn_state_t;

    // Default timing, 50 MHz CLK
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_DEB_CYCLES    = 500000;    // 10 ms
    localparam int unsigned DEF_DEB_W         = 20;
    localparam int unsigned DEF_REPEAT_DELAY  = 25000000;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD = 10000000;  // 200 ms
    localparam int unsigned DEF_RPT_W         = 25;

    // Smallest legal values for the timing parameters
    localparam int unsigned MIN_SYNC_STAGES   = 2;
    localparam int unsigned MIN_DEB_CYCLES    = 1;
    localparam int unsigned MIN_REPEAT_PERIOD = 2;

endpackage : btn_pulse_gen_pkg

// File: rtl/btn_pulse_gen_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
//   A SYNC_STAGES-deep flop chain that brings an asynchronous pad signal into
//   the i_clk domain. The chain clears to 0 asynchronously on reset.
//
//   Ports
//     i_clk    system clock
//     i_rst_n  asynchronous reset, active low
//     i_d      raw asynchronous input
//     o_q      synchronised output, i_d delayed by SYNC_STAGES flops
// -----------------------------------------------------------------------------
module btn_sync
    import btn_pulse_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule : btn_sync

// File: rtl/btn_pulse_gen.sv
// -----------------------------------------------------------------------------
// btn_pulse_gen
//   Front end for one mode/set push-button. The block does four things:
//     - synchronises BTN_IN into the CLK domain
//     - debounces both the press and the release
//     - emits a single-cycle BAP_BTN pulse for each accepted press
//     - with REPEAT_EN set, emits further repeat pulses while the button stays
//       held (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles)
//   All outputs are registered.
//
//   Ports
//     CLK         system clock
//     RESET       asynchronous reset, active low
//     BTN_IN      raw button, active high, asynchronous to CLK
//     REPEAT_EN   1 = auto-repeat allowed while held (synchronous)
//     BAP_BTN     one-CLK pulse per accepted press and per repeat
//     BTN_LEVEL   debounced button level (HELD, REPEAT, REL_DEB)
//     LONG_PRESS  high while in auto-repeat
// -----------------------------------------------------------------------------
module btn_pulse_gen
    import btn_pulse_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int unsigned DEB_W         = DEF_DEB_W,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned RPT_W         = DEF_RPT_W
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_IN,
    input  logic REPEAT_EN,
    output logic BAP_BTN,
    output logic BTN_LEVEL,
    output logic LONG_PRESS
);

    // Terminal counts; compares are exact, so counters never pass them
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

    logic             w_sync_btn;
    btn_state_t       r_state;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [RPT_W-1:0] r_hold_cnt;
    logic             r_bap;
    logic             r_level;
    logic             r_long;

    btn_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_d     (BTN_IN),
        .o_q     (w_sync_btn)
    );

    // Single FSM process; the outputs are set on the transitions into and
    // out of each state, so they change in the same cycle as the state.
    // A pulse due while r_bap is still high is deferred by one cycle: the
    // counter parks on its terminal value. This keeps BAP_BTN from ever
    // being high for two consecutive cycles.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_IDLE;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_bap      <= 1'b0;
            r_level    <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_bap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sync_btn) begin
                        r_state   <= ST_PRESS_DEB;
                        r_deb_cnt <= '0;
                    end
                end

                ST_PRESS_DEB: begin
                    if (!w_sync_btn) begin
                        r_state <= ST_IDLE;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state    <= ST_HELD;
                        r_hold_cnt <= '0;
                        r_bap      <= 1'b1;
                        r_level    <= 1'b1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_ONE;
                    end
                end

                ST_HELD: begin
                    if (!w_sync_btn) begin
                        r_state   <= ST_REL_DEB;
                        r_deb_cnt <= '0;
                    end else if (!REPEAT_EN) begin
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == DELAY_LAST) begin
                        if (!r_bap) begin
                            r_state    <= ST_REPEAT;
                            r_hold_cnt <= '0;
                            r_bap      <= 1'b1;
                            r_long     <= 1'b1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + RPT_ONE;
                    end
                end

                ST_REPEAT: begin
                    // Release wins over a coinciding terminal count.
                    if (!w_sync_btn) begin
                        r_state   <= ST_REL_DEB;
                        r_deb_cnt <= '0;
                        r_long    <= 1'b0;
                    end else if (!REPEAT_EN) begin
                        r_state    <= ST_HELD;
                        r_hold_cnt <= '0;
                        r_long     <= 1'b0;
                    end else if (r_hold_cnt == PER_LAST) begin
                        if (!r_bap) begin
                            r_hold_cnt <= '0;
                            r_bap      <= 1'b1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + RPT_ONE;
                    end
                end

                ST_REL_DEB: begin
                    if (w_sync_btn) begin
                        // A release glitch returns to HELD with a fresh repeat timer.
                        r_state    <= ST_HELD;
                        r_hold_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state <= ST_IDLE;
                        r_level <= 1'b0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_ONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_level <= 1'b0;
                    r_long  <= 1'b0;
                end
            endcase
        end
    end

    assign BAP_BTN    = r_bap;
    assign BTN_LEVEL  = r_level;
    assign LONG_PRESS = r_long;

endmodule : btn_pulse_gen
